uvma_axis_pkt_arb: RTL and testbench

//   Packet-locked round-robin arbiter/multiplexer for AMBA AXI-Stream.

---
 rtl/uvma_axis_pkt_arb.sv | 134 +++++++++++++
 tb/tb_uvma_axis_pkt_arb.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uvma_axis_pkt_arb.sv
// uvma_axis_pkt_arb: packet-locked round-robin arbiter that merges N_PORTS
// AXI-Stream inputs onto one registered AXI-Stream output. A grant is held
// from the first beat of a packet until its tlast beat has been accepted.

`ifndef UVMA_AXIS_TDATA_DEFAULT_WIDTH
`define UVMA_AXIS_TDATA_DEFAULT_WIDTH 4
`endif
`ifndef UVMA_AXIS_TUSER_DEFAULT_WIDTH
`define UVMA_AXIS_TUSER_DEFAULT_WIDTH 8
`endif
`ifndef UVMA_AXIS_TDEST_DEFAULT_WIDTH
`define UVMA_AXIS_TDEST_DEFAULT_WIDTH 4
`endif
`ifndef UVMA_AXIS_TID_DEFAULT_WIDTH
`define UVMA_AXIS_TID_DEFAULT_WIDTH 4
`endif

module uvma_axis_pkt_arb #(
  parameter int  N_PORTS     = 4,
  parameter int  TDATA_WIDTH = `UVMA_AXIS_TDATA_DEFAULT_WIDTH,
  parameter int  TUSER_WIDTH = `UVMA_AXIS_TUSER_DEFAULT_WIDTH,
  parameter int  TDEST_WIDTH = `UVMA_AXIS_TDEST_DEFAULT_WIDTH,
  parameter int  TID_WIDTH   = `UVMA_AXIS_TID_DEFAULT_WIDTH,
  localparam int SW          = $clog2(N_PORTS),
  localparam int DW          = TDATA_WIDTH * 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           arb_en,
  input  logic [N_PORTS-1:0]             s_mask,
  input  logic [N_PORTS-1:0]             s_tvalid,
  output logic [N_PORTS-1:0]             s_tready,
  input  logic [N_PORTS*DW-1:0]          s_tdata,
  input  logic [N_PORTS*TDATA_WIDTH-1:0] s_tstrb,
  input  logic [N_PORTS*TDATA_WIDTH-1:0] s_tkeep,
  input  logic [N_PORTS-1:0]             s_tlast,
  input  logic [N_PORTS*TID_WIDTH-1:0]   s_tid,
  input  logic [N_PORTS*TDEST_WIDTH-1:0] s_tdest,
  input  logic [N_PORTS*TUSER_WIDTH-1:0] s_tuser,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [DW-1:0]                  m_tdata,
  output logic [TDATA_WIDTH-1:0]         m_tstrb,
  output logic [TDATA_WIDTH-1:0]         m_tkeep,
  output logic                           m_tlast,
  output logic [TID_WIDTH-1:0]           m_tid,
  output logic [TDEST_WIDTH-1:0]         m_tdest,
  output logic [TUSER_WIDTH-1:0]         m_tuser,
  output logic [SW-1:0]                  m_tsrc,
  output logic                           busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state;
  logic [SW-1:0]   ptr;
  logic [SW-1:0]   grant;
  logic [SW-1:0]   pick;
  logic [SW:0]     scan_idx;
  logic [N_PORTS-1:0] req;
  logic            out_free;
  logic            accept;

  assign req      = s_tvalid & ~s_mask;
  assign out_free = ~m_tvalid | m_tready;
  assign accept   = (state == LOCK) & s_tvalid[grant] & out_free;
  assign busy     = (state == LOCK);

  // Round-robin pick: scanning in reverse leaves the first requester after ptr.
  always_comb begin
    pick     = '0;
    scan_idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      scan_idx = {1'b0, ptr} + (SW+1)'(i);
      if (scan_idx >= (SW+1)'(N_PORTS)) scan_idx = scan_idx - (SW+1)'(N_PORTS);
      if (req[scan_idx[SW-1:0]]) pick = scan_idx[SW-1:0];
    end
  end

  // Only the granted port sees tready, and only when the output register can take a beat.
  always_comb begin
    s_tready = '0;
    if (state == LOCK) s_tready[grant] = out_free;
  end

  // Arbitration FSM, fairness pointer and registered output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tstrb  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
      m_tdest  <= '0;
      m_tuser  <= '0;
      m_tsrc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_en && (|req)) begin
            grant <= pick;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (accept && s_tlast[grant]) begin
            state <= IDLE;
            ptr   <= (int'(grant) == N_PORTS - 1) ? '0 : grant + SW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        m_tvalid <= 1'b1;
        m_tdata  <= s_tdata[int'(grant)*DW +: DW];
        m_tstrb  <= s_tstrb[int'(grant)*TDATA_WIDTH +: TDATA_WIDTH];
        m_tkeep  <= s_tkeep[int'(grant)*TDATA_WIDTH +: TDATA_WIDTH];
        m_tlast  <= s_tlast[grant];
        m_tid    <= s_tid[int'(grant)*TID_WIDTH +: TID_WIDTH];
        m_tdest  <= s_tdest[int'(grant)*TDEST_WIDTH +: TDEST_WIDTH];
        m_tuser  <= s_tuser[int'(grant)*TUSER_WIDTH +: TUSER_WIDTH];
        m_tsrc   <= grant;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uvma_axis_pkt_arb.sv
// Bench for uvma_axis_pkt_arb: per-port packet sources, packet-level
// round-robin reference model and an output scoreboard.

module tb_uvma_axis_pkt_arb;

  localparam int N   = 4;
  localparam int DB  = 2;
  localparam int DW  = DB * 8;
  localparam int UW  = 4;
  localparam int DSW = 4;
  localparam int IW  = 4;
  localparam int SW  = 2;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [DB-1:0]  strb;
    logic [DB-1:0]  keep;
    logic           last;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
  } beat_t;

  typedef struct {
    beat_t b;
    int    src;
    int    cyc;
  } obs_t;

  logic             clk;
  logic             reset_n;
  logic             arb_en;
  logic [N-1:0]     s_mask;
  logic [N-1:0]     s_tvalid;
  logic [N-1:0]     s_tready;
  logic [N*DW-1:0]  s_tdata;
  logic [N*DB-1:0]  s_tstrb;
  logic [N*DB-1:0]  s_tkeep;
  logic [N-1:0]     s_tlast;
  logic [N*IW-1:0]  s_tid;
  logic [N*DSW-1:0] s_tdest;
  logic [N*UW-1:0]  s_tuser;
  logic             m_tvalid;
  logic             m_tready;
  logic [DW-1:0]    m_tdata;
  logic [DB-1:0]    m_tstrb;
  logic [DB-1:0]    m_tkeep;
  logic             m_tlast;
  logic [IW-1:0]    m_tid;
  logic [DSW-1:0]   m_tdest;
  logic [UW-1:0]    m_tuser;
  logic [SW-1:0]    m_tsrc;
  logic             busy;

  uvma_axis_pkt_arb #(
    .N_PORTS(N), .TDATA_WIDTH(DB), .TUSER_WIDTH(UW), .TDEST_WIDTH(DSW), .TID_WIDTH(IW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .arb_en(arb_en), .s_mask(s_mask),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .m_tsrc(m_tsrc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t       q[N][$];   // what each source still has to send
  beat_t       mq[N][$];  // reference model's copy of the same traffic
  obs_t        got[$];
  obs_t        expq[$];
  int          mptr;
  int          n_chk;
  int          n_pass;
  int          cyc;
  int          src_pkts;
  logic        rnd_rdy;
  logic        rdy_val;
  logic        prev_stall;
  logic [63:0] stall_snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] mword();
    return 64'({m_tsrc, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser});
  endfunction

  function automatic logic [63:0] pword(input int src, input beat_t b);
    return 64'({SW'(src), b});
  endfunction

  function automatic beat_t rnd_beat(input logic last);
    beat_t b;
    b.data = DW'($urandom);
    b.strb = DB'($urandom);
    b.keep = DB'($urandom);
    b.last = last;
    b.id   = IW'($urandom);
    b.dest = DSW'($urandom);
    b.user = UW'($urandom);
    return b;
  endfunction

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = rnd_beat(i == len - 1);
      q[p].push_back(b);
      mq[p].push_back(b);
    end
  endtask

  // Reference: whole packets, next one from the first non-empty eligible
  // port at or after the pointer; the served port then goes to the back.
  task automatic plan(input int npkt, input logic [N-1:0] mask);
    int   sel;
    int   p;
    logic last;
    obs_t o;
    for (int k = 0; k < npkt; k++) begin
      sel = -1;
      for (int i = 0; i < N; i++) begin
        p = (mptr + i) % N;
        if (sel < 0 && mq[p].size() > 0 && !mask[p]) sel = p;
      end
      if (sel < 0) break;
      last = 1'b0;
      while (!last && mq[sel].size() > 0) begin
        o.b   = mq[sel].pop_front();
        o.src = sel;
        o.cyc = 0;
        last  = o.b.last;
        expq.push_back(o);
      end
      mptr = (sel + 1) % N;
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int p = 0; p < N; p++) begin
      b = '0;
      s_tvalid[p] = (q[p].size() > 0);
      if (q[p].size() > 0) b = q[p][0];
      s_tdata[p*DW +: DW]   = b.data;
      s_tstrb[p*DB +: DB]   = b.strb;
      s_tkeep[p*DB +: DB]   = b.keep;
      s_tlast[p]            = b.last;
      s_tid[p*IW +: IW]     = b.id;
      s_tdest[p*DSW +: DSW] = b.dest;
      s_tuser[p*UW +: UW]   = b.user;
    end
    if (rnd_rdy) m_tready = ($urandom_range(0, 3) != 0);
    else         m_tready = rdy_val;
  endtask

  // One clock: observe at the falling edge, retire accepted beats after the rising edge.
  task automatic tick();
    logic [N-1:0] acc;
    obs_t o;
    @(negedge clk);
    acc = s_tvalid & s_tready;
    if (prev_stall) chk("stall_hold", mword(), stall_snap);
    prev_stall = m_tvalid & ~m_tready;
    stall_snap = mword();
    if (m_tvalid && m_tready) begin
      o.b   = '{data: m_tdata, strb: m_tstrb, keep: m_tkeep, last: m_tlast,
                id: m_tid, dest: m_tdest, user: m_tuser};
      o.src = int'(m_tsrc);
      o.cyc = cyc;
      got.push_back(o);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < N; p++) begin
      if (acc[p] && q[p].size() > 0) begin
        if (q[p][0].last) src_pkts++;
        void'(q[p].pop_front());
      end
    end
    drive();
  endtask

  task automatic drain(input int budget, input bit gapchk);
    int n;
    n = 0;
    while (got.size() < expq.size() && n < budget) begin
      tick();
      n++;
    end
    chk("drain_count", 64'(got.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      chk("beat", pword(got[i].src, got[i].b), pword(expq[i].src, expq[i].b));
      if (gapchk && i > 0)
        chk("gap", 64'(got[i].cyc - got[i-1].cyc), got[i-1].b.last ? 64'd2 : 64'd1);
    end
    got.delete();
    expq.delete();
  endtask

  initial begin
    int    n;
    int    base;
    beat_t b2;
    n_chk = 0; n_pass = 0; cyc = 0; src_pkts = 0; mptr = 0;
    prev_stall = 1'b0; stall_snap = '0;
    rnd_rdy = 1'b0; rdy_val = 1'b1;
    arb_en = 1'b1; s_mask = '0; reset_n = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_payload", mword(), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // All four ports, one 3-beat packet each, continuous ready.
    for (int p = 0; p < N; p++) add_pkt(p, 3);
    plan(4, '0);
    drive();
    drain(100, 1'b1);

    // Port 2, 4 beats, output stalled 3 cycles while beat 2 is presented.
    add_pkt(2, 4);
    plan(1, '0);
    drive();
    b2 = q[2][1];
    n = 0;
    while (!(m_tvalid && m_tdata === b2.data) && n < 20) begin
      tick();
      n++;
    end
    chk("t2_reach_beat2", 64'(n < 20), 64'd1);
    rdy_val = 1'b0;
    m_tready = 1'b0;
    repeat (3) begin
      tick();
      chk("t2_hold_data", 64'(m_tdata), 64'(b2.data));
      chk("t2_s_tready", 64'(s_tready[2]), 64'd0);
    end
    rdy_val = 1'b1;
    m_tready = 1'b1;
    drain(50, 1'b0);

    // Ports 1 and 3 busy, port 1 masked for two packets, then unmasked.
    rnd_rdy = 1'b1;
    add_pkt(1, $urandom_range(1, 3));
    add_pkt(1, $urandom_range(1, 3));
    for (int k = 0; k < 4; k++) add_pkt(3, $urandom_range(1, 3));
    plan(2, 4'b0010);
    plan(4, '0);
    s_mask = 4'b0010;
    base = src_pkts;
    drive();
    n = 0;
    while (src_pkts < base + 2 && n < 100) begin
      tick();
      n++;
    end
    chk("t3_masked_pkts", 64'(src_pkts - base), 64'd2);
    s_mask = '0;
    drain(300, 1'b0);
    rnd_rdy = 1'b0;

    // arb_en dropped mid-packet: packet completes, port 1 waits.
    add_pkt(0, 5);
    add_pkt(1, 2);
    plan(2, '0);
    drive();
    n = 0;
    while (q[0].size() > 3 && n < 50) begin
      tick();
      n++;
    end
    arb_en = 1'b0;
    base = src_pkts;
    n = 0;
    while (src_pkts == base && n < 50) begin
      tick();
      n++;
    end
    chk("t4_tlast_accepted", 64'(src_pkts - base), 64'd1);
    chk("t4_busy_fall", 64'(busy), 64'd0);
    repeat (5) begin
      tick();
      chk("t4_busy_idle", 64'(busy), 64'd0);
      chk("t4_port1_waits", 64'(q[1].size()), 64'd2);
    end
    arb_en = 1'b1;
    drain(100, 1'b0);

    // Reset on beat 3 of a 6-beat packet.
    add_pkt(0, 6);
    drive();
    n = 0;
    while (q[0].size() > 3 && n < 50) begin
      tick();
      n++;
    end
    reset_n = 1'b0;
    #1;
    chk("t5_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t5_s_tready", 64'(s_tready), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_payload", mword(), 64'd0);
    for (int p = 0; p < N; p++) begin
      q[p].delete();
      mq[p].delete();
    end
    got.delete();
    expq.delete();
    mptr = 0;
    prev_stall = 1'b0;
    drive();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    add_pkt(0, 2);
    add_pkt(1, 2);
    plan(2, '0);
    drive();
    drain(50, 1'b1);

    // Single-beat packets on every port: one beat per two cycles.
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < N; p++) add_pkt(p, 1);
    plan(12, '0);
    drive();
    drain(100, 1'b1);

    // Random traffic with random backpressure.
    rnd_rdy = 1'b1;
    repeat (3) begin
      for (int p = 0; p < N; p++) begin
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) add_pkt(p, $urandom_range(1, 5));
      end
      plan(100, '0);
      drive();
      drain(2000, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
